// File: rtl/pb_gesture_if.sv
// ---------------------------------------------------------------------------
// pb_gesture_if
// Bundles the push-button gesture decoder's inputs and event outputs.
//   tick          timebase strobe, one clk wide
//   pb_down       debouncer strobe: button just pressed
//   pb_up         debouncer strobe: button just released
//   short_press   one-cycle pulse: single short press completed
//   double_press  one-cycle pulse: second press of a double detected
//   long_press    one-cycle pulse: press held for the long-press time
//   repeat_pulse  one-cycle pulse: auto-repeat while held past long
//   busy          decoder is in the middle of a gesture
// master: the side that drives the strobes (debouncer / testbench)
// slave : the gesture decoder
// ---------------------------------------------------------------------------
interface pb_gesture_if;
   logic tick;
   logic pb_down;
   logic pb_up;
   logic short_press;
   logic double_press;
   logic long_press;
   logic repeat_pulse;
   logic busy;

   modport master (
      output tick, pb_down, pb_up,
      input  short_press, double_press, long_press, repeat_pulse, busy
   );

   modport slave (
      input  tick, pb_down, pb_up,
      output short_press, double_press, long_press, repeat_pulse, busy
   );
endinterface

// File: rtl/pb_gesture_decoder.sv
// ---------------------------------------------------------------------------
// pb_gesture_decoder
// Classifies push-button gestures (short, double, long + auto-repeat) from
// the debouncer's press/release strobes, timing everything in tick strobes.
// Ports:
//   clk    system clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    pb_gesture_if.slave: tick/pb_down/pb_up in; short_press,
//          double_press, long_press, repeat_pulse (registered one-cycle
//          pulses) and busy (state != IDLE) out
// ---------------------------------------------------------------------------
module pb_gesture_decoder #(
   parameter int CNT_W         = 12,
   parameter int LONG_TICKS    = 1000,
   parameter int DBL_GAP_TICKS = 300,
   parameter int REPEAT_TICKS  = 200
) (
   input  logic         clk,
   input  logic         rst_n,
   pb_gesture_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      HELD   = 3'd4
   } state_t;

   // "Reaches N" is a tick while the counter sits at N-1.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_TICKS - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             short_r;
   logic             double_r;
   logic             long_r;
   logic             repeat_r;

   logic             down_s;
   logic             up_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             long_reach_s;
   logic             gap_reach_s;
   logic             rep_reach_s;

   // Simultaneous press and release strobes are a glitch and cancel out.
   assign down_s = bus.pb_down & ~bus.pb_up;
   assign up_s   = bus.pb_up & ~bus.pb_down;

   // Counter advances on tick and saturates instead of wrapping.
   assign cnt_inc_s = (bus.tick && (cnt_r != CNT_MAX)) ? (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_r;

   assign long_reach_s = bus.tick && (cnt_r == LONG_LAST);
   assign gap_reach_s  = bus.tick && (cnt_r == GAP_LAST);
   assign rep_reach_s  = bus.tick && (cnt_r == REP_LAST);

   // Gesture FSM with tick counter and registered event pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= CNT_ZERO;
         short_r  <= 1'b0;
         double_r <= 1'b0;
         long_r   <= 1'b0;
         repeat_r <= 1'b0;
      end else begin
         short_r  <= 1'b0;
         double_r <= 1'b0;
         long_r   <= 1'b0;
         repeat_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (down_s) begin
                  state_r <= PRESS1;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r   <= cnt_inc_s;
               end
            end
            PRESS1: begin
               // Release beats a coincident long-press threshold.
               if (up_s) begin
                  state_r <= WAIT2;
                  cnt_r   <= CNT_ZERO;
               end else if (long_reach_s) begin
                  state_r <= HELD;
                  cnt_r   <= CNT_ZERO;
                  long_r  <= 1'b1;
               end else begin
                  cnt_r   <= cnt_inc_s;
               end
            end
            WAIT2: begin
               // A second press beats a coincident gap timeout.
               if (down_s) begin
                  state_r  <= PRESS2;
                  cnt_r    <= CNT_ZERO;
                  double_r <= 1'b1;
               end else if (gap_reach_s) begin
                  state_r  <= IDLE;
                  cnt_r    <= CNT_ZERO;
                  short_r  <= 1'b1;
               end else begin
                  cnt_r    <= cnt_inc_s;
               end
            end
            PRESS2: begin
               if (up_s) begin
                  state_r <= IDLE;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r   <= cnt_inc_s;
               end
            end
            HELD: begin
               if (up_s) begin
                  state_r  <= IDLE;
                  cnt_r    <= CNT_ZERO;
               end else if (rep_reach_s) begin
                  cnt_r    <= CNT_ZERO;
                  repeat_r <= 1'b1;
               end else begin
                  cnt_r    <= cnt_inc_s;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

   assign bus.short_press  = short_r;
   assign bus.double_press = double_r;
   assign bus.long_press   = long_r;
   assign bus.repeat_pulse = repeat_r;
   assign bus.busy         = (state_r != IDLE);

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// ---------------------------------------------------------------------------
// tb_pb_gesture_decoder
// Directed gesture scenarios followed by randomized strobes, all compared
// cycle by cycle against a gesture-level reference model.
// ---------------------------------------------------------------------------
module tb_pb_gesture_decoder;

   localparam int LONG = 4;
   localparam int GAP  = 3;
   localparam int REP  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   pb_gesture_if bus ();

   pb_gesture_decoder #(
      .CNT_W(12), .LONG_TICKS(LONG), .DBL_GAP_TICKS(GAP), .REPEAT_TICKS(REP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: describes the gesture in progress, not the RTL states.
   bit         m_pressed;   // a press is being timed
   bit         m_waiting;   // released after a first press, awaiting a second
   bit         m_second;    // current press is the second of a double
   bit         m_long;      // long already fired in this hold
   int         m_ticks;     // ticks since the current phase began
   logic [4:0] m_exp;       // {short, double, long, repeat, busy}

   bit         tick_rand = 1'b0;
   logic [1:0] phase = 2'd0;
   bit         last_t;
   int         sc_short, sc_double, sc_long, sc_rep;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic void model_reset();
      m_pressed = 1'b0; m_waiting = 1'b0; m_second = 1'b0; m_long = 1'b0;
      m_ticks = 0; m_exp = 5'b0;
   endfunction

   function automatic void model_step(input bit d, input bit u, input bit t);
      bit dn;
      bit up;
      bit e_short, e_double, e_long, e_rep;
      dn = d && !u;
      up = u && !d;
      e_short = 1'b0; e_double = 1'b0; e_long = 1'b0; e_rep = 1'b0;
      if (m_waiting) begin
         if (dn) begin
            e_double = 1'b1;
            m_waiting = 1'b0; m_pressed = 1'b1; m_second = 1'b1; m_ticks = 0;
         end else if (t) begin
            m_ticks++;
            if (m_ticks == GAP) begin
               e_short = 1'b1;
               m_waiting = 1'b0;
            end
         end
      end else if (m_pressed) begin
         if (up) begin
            m_waiting = !m_second && !m_long;
            m_pressed = 1'b0;
            m_ticks = 0;
         end else if (!m_second && t) begin
            m_ticks++;
            if (!m_long && m_ticks == LONG) begin
               e_long = 1'b1; m_long = 1'b1; m_ticks = 0;
            end else if (m_long && m_ticks == REP) begin
               e_rep = 1'b1; m_ticks = 0;
            end
         end
      end else if (dn) begin
         m_pressed = 1'b1; m_second = 1'b0; m_long = 1'b0; m_ticks = 0;
      end
      m_exp = {e_short, e_double, e_long, e_rep, m_pressed || m_waiting};
   endfunction

   function automatic logic [4:0] outs();
      return {bus.short_press, bus.double_press, bus.long_press, bus.repeat_pulse, bus.busy};
   endfunction

   task automatic clear_counts();
      sc_short = 0; sc_double = 0; sc_long = 0; sc_rep = 0;
   endtask

   // One clock: drive at negedge, check #1 after posedge.
   task automatic step(input bit d, input bit u);
      bit t;
      logic [4:0] got;
      @(negedge clk);
      t = tick_rand ? ($urandom_range(2, 0) == 0) : (phase == 2'd3);
      phase = phase + 2'd1;
      bus.pb_down = d; bus.pb_up = u; bus.tick = t;
      last_t = t;
      model_step(d, u, t);
      @(posedge clk);
      #1;
      got = outs();
      chk("cycle", {27'd0, got}, {27'd0, m_exp});
      if ($countones(got[4:1]) > 1) chk("onehot", {27'd0, got}, {27'd0, m_exp});
      sc_short  += int'(got[4]);
      sc_double += int'(got[3]);
      sc_long   += int'(got[2]);
      sc_rep    += int'(got[1]);
   endtask

   task automatic idle_ticks(input int n);
      int k = 0;
      while (k < n) begin
         step(1'b0, 1'b0);
         if (last_t) k++;
      end
   endtask

   // Drive the strobes in the next cycle that carries a tick.
   task automatic step_tick(input bit d, input bit u);
      while (phase != 2'd3) step(1'b0, 1'b0);
      step(d, u);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      bus.pb_down = 1'b0; bus.pb_up = 1'b0; bus.tick = 1'b0;
      #1;
      chk(tag, {27'd0, outs()}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.pb_down = 1'b0; bus.pb_up = 1'b0; bus.tick = 1'b0;
      model_reset();
      #1 rst_n = 1'b0;
      #2 chk("reset_state", {27'd0, outs()}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Short press
      clear_counts();
      step(1'b1, 1'b0); idle_ticks(2); step(1'b0, 1'b1); idle_ticks(3); step(1'b0, 1'b0);
      chk("s1_short", sc_short, 1);
      chk("s1_others", sc_double + sc_long + sc_rep, 0);
      chk("s1_busy", {31'd0, bus.busy}, 32'd0);

      // Double press
      clear_counts();
      step(1'b1, 1'b0); idle_ticks(1); step(1'b0, 1'b1); idle_ticks(1); step(1'b1, 1'b0);
      idle_ticks(1); step(1'b0, 1'b1); step(1'b0, 1'b0);
      chk("s2_busy", {31'd0, bus.busy}, 32'd0);
      idle_ticks(4);
      chk("s2_double", sc_double, 1);
      chk("s2_short", sc_short, 0);

      // Long press with repeat
      clear_counts();
      step(1'b1, 1'b0); idle_ticks(9); step(1'b0, 1'b1); idle_ticks(4);
      chk("s3_long", sc_long, 1);
      chk("s3_repeat", sc_rep, 2);
      chk("s3_short", sc_short + sc_double, 0);

      // Race: release on the long threshold tick
      clear_counts();
      step(1'b1, 1'b0); idle_ticks(3); step_tick(1'b0, 1'b1); idle_ticks(4);
      chk("s4a_long", sc_long, 0);
      chk("s4a_short", sc_short, 1);

      // Race: second press on the gap timeout tick
      clear_counts();
      step(1'b1, 1'b0); idle_ticks(1); step(1'b0, 1'b1); idle_ticks(2); step_tick(1'b1, 1'b0);
      step(1'b0, 1'b0); step(1'b0, 1'b1); idle_ticks(4);
      chk("s4b_double", sc_double, 1);
      chk("s4b_short", sc_short, 0);

      // Glitch and stray strobes
      clear_counts();
      step(1'b1, 1'b1);
      chk("s5a_busy", {31'd0, bus.busy}, 32'd0);
      step(1'b0, 1'b1); idle_ticks(4);
      chk("s5_pulses", sc_short + sc_double + sc_long + sc_rep, 0);

      // Reset while held, then while waiting for the second press
      step(1'b1, 1'b0); idle_ticks(5);
      chk("s6_held_busy", {31'd0, bus.busy}, 32'd1);
      do_reset("s6_rst_held");
      clear_counts();
      idle_ticks(4);
      chk("s6_after_held", sc_short + sc_double + sc_long + sc_rep, 0);
      step(1'b1, 1'b0); idle_ticks(1); step(1'b0, 1'b1); step(1'b0, 1'b0);
      chk("s6_wait_busy", {31'd0, bus.busy}, 32'd1);
      do_reset("s6_rst_wait");
      clear_counts();
      idle_ticks(4);
      chk("s6_after_wait", sc_short + sc_double + sc_long + sc_rep, 0);

      // Randomized strobes and ticks, with occasional mid-gesture reset
      tick_rand = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = int'($urandom_range(999, 0));
         if (r < 3) do_reset("rand_rst");
         else step(r < 60 || r == 999, (r >= 60 && r < 120) || r == 999);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
